// File: rtl/dbus_ram_arbiter.sv
// Round-robin arbiter sharing the RAM data port between the CPU dBus (m0) and an
// auxiliary master (m1); routes 1-cycle read data back to the issuing requester.
module dbus_ram_arbiter #(
  parameter int WL          = 32,
  parameter int RAM_DEPTH   = 8192,
  parameter int RAM_ADDR_WL = $clog2(RAM_DEPTH - 1),
  parameter int ERR_CNT_WL  = 8
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   m0_cmd_valid,
  output logic                   m0_cmd_ready,
  input  logic                   m0_cmd_wr,
  input  logic [WL-1:0]          m0_cmd_addr,
  input  logic [WL-1:0]          m0_cmd_data,
  input  logic [1:0]             m0_cmd_size,
  output logic                   m0_rsp_valid,
  output logic                   m0_rsp_error,
  output logic [WL-1:0]          m0_rsp_data,
  input  logic                   m1_cmd_valid,
  output logic                   m1_cmd_ready,
  input  logic                   m1_cmd_wr,
  input  logic [WL-1:0]          m1_cmd_addr,
  input  logic [WL-1:0]          m1_cmd_data,
  input  logic [1:0]             m1_cmd_size,
  output logic                   m1_rsp_valid,
  output logic                   m1_rsp_error,
  output logic [WL-1:0]          m1_rsp_data,
  output logic [WL/8-1:0]        ram_we,
  output logic [RAM_ADDR_WL-1:0] ram_addr,
  output logic [WL-1:0]          ram_din,
  input  logic [WL-1:0]          ram_dout,
  output logic [ERR_CNT_WL-1:0]  err_count
);

  localparam int NB = WL / 8;

  logic                   last_grant;
  logic                   grant0, grant1, accept;
  logic                   sel_wr, sel_oor;
  logic [WL-1:0]          sel_addr;
  logic [1:0]             sel_size;
  logic                   rsp_pend, rsp_owner, rsp_err;
  logic [WL-1:0]          rsp_word;
  logic [WL-1:0]          held0, held1;

  // Ready is gated by resetn so nothing is offered while reset is asserted.
  always_comb begin
    grant0   = resetn & m0_cmd_valid & (~m1_cmd_valid | last_grant);
    grant1   = resetn & m1_cmd_valid & (~m0_cmd_valid | ~last_grant);
    accept   = grant0 | grant1;
    sel_wr   = grant1 ? m1_cmd_wr   : m0_cmd_wr;
    sel_addr = grant1 ? m1_cmd_addr : m0_cmd_addr;
    sel_size = grant1 ? m1_cmd_size : m0_cmd_size;
    ram_din  = grant1 ? m1_cmd_data : m0_cmd_data;
    ram_addr = sel_addr[RAM_ADDR_WL+1:2];
    sel_oor  = |sel_addr[WL-1:RAM_ADDR_WL+2];
  end

  assign m0_cmd_ready = grant0;
  assign m1_cmd_ready = grant1;

  always_comb begin
    ram_we = '0;
    if (accept && sel_wr && !sel_oor) begin
      case (sel_size)
        2'd0:    ram_we = NB'(1) << sel_addr[1:0];
        2'd1:    ram_we = NB'(3) << {sel_addr[1], 1'b0};
        default: ram_we = '1;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      last_grant <= 1'b1;
      rsp_pend   <= 1'b0;
      rsp_owner  <= 1'b0;
      rsp_err    <= 1'b0;
      held0      <= '0;
      held1      <= '0;
      err_count  <= '0;
    end else begin
      if (accept) last_grant <= grant1;
      rsp_pend  <= accept & ~sel_wr;
      rsp_owner <= grant1;
      rsp_err   <= sel_oor;
      if (rsp_pend && !rsp_owner) held0 <= rsp_word;
      if (rsp_pend &&  rsp_owner) held1 <= rsp_word;
      if (accept && sel_oor && !(&err_count)) err_count <= err_count + ERR_CNT_WL'(1);
    end
  end

  // RAM data arrives in the response cycle, so it is passed through combinationally
  // and captured into the per-owner hold register for the following cycles.
  assign rsp_word     = rsp_err ? '0 : ram_dout;
  assign m0_rsp_valid = rsp_pend & ~rsp_owner;
  assign m1_rsp_valid = rsp_pend &  rsp_owner;
  assign m0_rsp_error = m0_rsp_valid & rsp_err;
  assign m1_rsp_error = m1_rsp_valid & rsp_err;
  assign m0_rsp_data  = m0_rsp_valid ? rsp_word : held0;
  assign m1_rsp_data  = m1_rsp_valid ? rsp_word : held1;

endmodule

// File: tb/tb_dbus_ram_arbiter.sv
// Randomized bench for dbus_ram_arbiter against a transaction-level model of
// arbitration, byte lanes, RAM contents, responses and the error counter.
module tb_dbus_ram_arbiter;

  localparam int WL = 32;
  localparam int RAM_DEPTH = 8192;
  localparam int AW = 13;

  logic clk = 1'b0;
  logic resetn;
  logic m0_cmd_valid, m0_cmd_ready, m0_cmd_wr, m0_rsp_valid, m0_rsp_error;
  logic m1_cmd_valid, m1_cmd_ready, m1_cmd_wr, m1_rsp_valid, m1_rsp_error;
  logic [31:0] m0_cmd_addr, m0_cmd_data, m0_rsp_data;
  logic [31:0] m1_cmd_addr, m1_cmd_data, m1_rsp_data;
  logic [1:0]  m0_cmd_size, m1_cmd_size;
  logic [3:0]  ram_we;
  logic [AW-1:0] ram_addr;
  logic [31:0] ram_din, ram_dout;
  logic [7:0]  err_count;

  dbus_ram_arbiter #(.WL(WL), .RAM_DEPTH(RAM_DEPTH), .ERR_CNT_WL(8)) dut (
    .clk(clk), .resetn(resetn),
    .m0_cmd_valid(m0_cmd_valid), .m0_cmd_ready(m0_cmd_ready), .m0_cmd_wr(m0_cmd_wr),
    .m0_cmd_addr(m0_cmd_addr), .m0_cmd_data(m0_cmd_data), .m0_cmd_size(m0_cmd_size),
    .m0_rsp_valid(m0_rsp_valid), .m0_rsp_error(m0_rsp_error), .m0_rsp_data(m0_rsp_data),
    .m1_cmd_valid(m1_cmd_valid), .m1_cmd_ready(m1_cmd_ready), .m1_cmd_wr(m1_cmd_wr),
    .m1_cmd_addr(m1_cmd_addr), .m1_cmd_data(m1_cmd_data), .m1_cmd_size(m1_cmd_size),
    .m1_rsp_valid(m1_rsp_valid), .m1_rsp_error(m1_rsp_error), .m1_rsp_data(m1_rsp_data),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout),
    .err_count(err_count)
  );

  always #5 clk = ~clk;

  // Synchronous RAM attached to the data port.
  logic [31:0] ram_mem [RAM_DEPTH];
  always @(posedge clk) begin
    for (int k = 0; k < 4; k++)
      if (ram_we[k]) ram_mem[ram_addr][8*k +: 8] <= ram_din[8*k +: 8];
    ram_dout <= ram_mem[ram_addr];
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  logic [31:0] ref_mem [RAM_DEPTH];
  int          turn;          // who wins a tie next
  int          errs;
  bit          pend_valid;
  int          pend_owner;
  bit          pend_err;
  logic [31:0] pend_data;
  logic [31:0] held [2];

  function automatic logic [3:0] lanes_of(input logic [1:0] size, input logic [1:0] off);
    int n, base;
    logic [3:0] m;
    n = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    base = (int'(off) / n) * n;
    m = '0;
    for (int k = 0; k < n; k++) m[base + k] = 1'b1;
    return m;
  endfunction

  task automatic model_reset();
    turn = 0; errs = 0; pend_valid = 0; pend_owner = 0; pend_err = 0;
    pend_data = '0; held[0] = '0; held[1] = '0;
  endtask

  task automatic drive_cycle(input logic v0, input logic w0, input logic [31:0] a0,
                             input logic [31:0] d0, input logic [1:0] s0,
                             input logic v1, input logic w1, input logic [31:0] a1,
                             input logic [31:0] d1, input logic [1:0] s1, output int win);
    logic [31:0] a, d;
    logic        w, oor, exp_v;
    logic [1:0]  s;
    logic [3:0]  be;
    logic        rv [2];
    logic        re [2];
    logic [31:0] rd [2];
    @(negedge clk);
    m0_cmd_valid = v0; m0_cmd_wr = w0; m0_cmd_addr = a0; m0_cmd_data = d0; m0_cmd_size = s0;
    m1_cmd_valid = v1; m1_cmd_wr = w1; m1_cmd_addr = a1; m1_cmd_data = d1; m1_cmd_size = s1;
    #1;
    rv[0] = m0_rsp_valid; re[0] = m0_rsp_error; rd[0] = m0_rsp_data;
    rv[1] = m1_rsp_valid; re[1] = m1_rsp_error; rd[1] = m1_rsp_data;
    for (int m = 0; m < 2; m++) begin
      exp_v = pend_valid && (pend_owner == m);
      check($sformatf("rsp_valid%0d", m), rv[m], exp_v);
      check($sformatf("rsp_error%0d", m), re[m], exp_v ? pend_err : 1'b0);
      check($sformatf("rsp_data%0d", m), rd[m], exp_v ? pend_data : held[m]);
    end
    if (pend_valid) held[pend_owner] = pend_data;
    pend_valid = 0;

    if (v0 && v1) win = turn;
    else if (v0)  win = 0;
    else if (v1)  win = 1;
    else          win = -1;
    check("ready0", m0_cmd_ready, win == 0);
    check("ready1", m1_cmd_ready, win == 1);
    check("err_count", err_count, (errs > 255) ? 255 : errs);

    if (win < 0) begin
      check("we_idle", ram_we, 4'b0000);
    end else begin
      a = win ? a1 : a0; d = win ? d1 : d0; w = win ? w1 : w0; s = win ? s1 : s0;
      oor = (a >= 32'(RAM_DEPTH * 4));
      be = (w && !oor) ? lanes_of(s, a[1:0]) : 4'b0000;
      check("ram_addr", ram_addr, (a / 4) % RAM_DEPTH);
      check("ram_din", ram_din, d);
      check("ram_we", ram_we, be);
      turn = 1 - win;
      if (oor) errs++;
      for (int k = 0; k < 4; k++)
        if (be[k]) ref_mem[(a / 4) % RAM_DEPTH][8*k +: 8] = d[8*k +: 8];
      if (!w) begin
        pend_valid = 1; pend_owner = win; pend_err = oor;
        pend_data = oor ? 32'h0 : ref_mem[(a / 4) % RAM_DEPTH];
      end
    end
  endtask

  task automatic idle(output int win);
    drive_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, win);
  endtask

  int w;
  logic [31:0] oor_addr, ra, rdat;

  initial begin
    for (int i = 0; i < RAM_DEPTH; i++) begin
      ram_mem[i] = '0;
      ref_mem[i] = '0;
    end
    model_reset();
    resetn = 1'b0;
    m0_cmd_valid = 1; m0_cmd_wr = 1; m0_cmd_addr = 32'h10; m0_cmd_data = 32'h1; m0_cmd_size = 2;
    m1_cmd_valid = 1; m1_cmd_wr = 1; m1_cmd_addr = 32'h20; m1_cmd_data = 32'h2; m1_cmd_size = 2;
    repeat (2) @(negedge clk);
    check("rst_ready0", m0_cmd_ready, 1'b0);
    check("rst_ready1", m1_cmd_ready, 1'b0);
    check("rst_we", ram_we, 4'b0000);
    check("rst_rsp_valid", {m0_rsp_valid, m1_rsp_valid, m0_rsp_error, m1_rsp_error}, 4'b0000);
    check("rst_rsp_data", {m0_rsp_data, m1_rsp_data}, 64'h0);
    check("rst_err_count", err_count, 8'h0);
    m0_cmd_valid = 0; m1_cmd_valid = 0;
    resetn = 1'b1;

    // Single write then read
    drive_cycle(1, 1, 32'h10, 32'hDEADBEEF, 2, 0, 0, 0, 0, 0, w);
    check("wr_we", ram_we, 4'b1111);
    check("wr_addr", ram_addr, 13'd4);
    drive_cycle(1, 0, 32'h10, 0, 2, 0, 0, 0, 0, 0, w);
    idle(w);
    check("rd_valid0", m0_rsp_valid, 1'b1);
    check("rd_data0", m0_rsp_data, 32'hDEADBEEF);
    check("rd_valid1", m1_rsp_valid, 1'b0);

    // Byte / half enables
    drive_cycle(0, 0, 0, 0, 0, 1, 1, 32'h23, 32'hAB00_0000, 0, w);
    check("byte_we", ram_we, 4'b1000);
    check("byte_addr", ram_addr, 13'd8);
    drive_cycle(0, 0, 0, 0, 0, 1, 1, 32'h22, 32'h1234_0000, 1, w);
    check("half_we", ram_we, 4'b1100);

    // Out of range and saturation
    drive_cycle(1, 0, 32'h0001_0000, 0, 2, 0, 0, 0, 0, 0, w);
    idle(w);
    check("oor_error", m0_rsp_error, 1'b1);
    check("oor_data", m0_rsp_data, 32'h0);
    check("oor_cnt1", err_count, 8'd1);
    drive_cycle(0, 0, 0, 0, 0, 1, 1, 32'h0001_0000, 32'hFFFF_FFFF, 2, w);
    check("oor_we", ram_we, 4'b0000);
    idle(w);
    check("oor_cnt2", err_count, 8'd2);
    for (int i = 0; i < 298; i++)
      drive_cycle(i % 2 == 0, $urandom_range(0, 1), 32'h0001_0000 + 32'($urandom_range(0, 255)),
                  $urandom, 2, i % 2 == 1, $urandom_range(0, 1), 32'hFFFF_0000, $urandom, 0, w);
    idle(w);
    check("oor_sat", err_count, 8'd255);

    // Reset with a read in flight
    drive_cycle(0, 0, 0, 0, 0, 1, 0, 32'h10, 0, 2, w);
    check("mid_ready1", m1_cmd_ready, 1'b1);
    resetn = 1'b0;
    model_reset();
    #1;
    check("mid_rst_ready1", m1_cmd_ready, 1'b0);
    check("mid_rst_cnt", err_count, 8'h0);
    m1_cmd_valid = 0;
    @(posedge clk);
    @(posedge clk);
    #2 resetn = 1'b1;

    // Contention straight out of reset: m0, m1, m0, m1 with back-to-back responses
    for (int k = 0; k < 4; k++) begin
      drive_cycle(1, 0, 32'h10, 0, 2, 1, 0, 32'h20 + 32'(4 * k), 0, 2, w);
      check($sformatf("cont_g0_%0d", k), m0_cmd_ready, k % 2 == 0);
      if (k > 0) check($sformatf("cont_rsp_%0d", k), {m0_rsp_valid, m1_rsp_valid},
                       (k % 2 == 1) ? 2'b10 : 2'b01);
    end

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      logic v0r, v1r;
      logic [31:0] a0r, a1r;
      v0r = ($urandom_range(0, 3) != 0);
      v1r = ($urandom_range(0, 2) != 0);
      a0r = ($urandom_range(0, 9) == 0) ? ({$urandom} | 32'h0000_8000) : 32'($urandom_range(0, 255));
      a1r = ($urandom_range(0, 9) == 0) ? ({$urandom} | 32'h8000_0000) : 32'($urandom_range(0, 255));
      if ($urandom_range(0, 15) == 0) a0r = 32'h7FFC + 32'($urandom_range(0, 3));
      drive_cycle(v0r, $urandom_range(0, 1), a0r, $urandom, 2'($urandom_range(0, 3)),
                  v1r, $urandom_range(0, 1), a1r, $urandom, 2'($urandom_range(0, 3)), w);
    end
    idle(w);
    idle(w);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/dbus_ram_arbiter.md
Name: dbus_ram_arbiter

Overview:
- Shares the single data-side port of the dual-port VexRiscv RAM between two requesters:
  - m0: the CPU dBus.
  - m1: an auxiliary master, e.g. a UART boot loader or DMA.
- Round-robin arbitration, one command accepted per cycle.
- Translates byte addresses and sizes into word address and byte write-enables.
- Routes the 1-cycle synchronous read data back to the requester that issued the read; out-of-range accesses are flagged and counted.
- Sits between the CPU/aux masters and the RAM dBus port, in parallel with the IO select logic.

Parameters:
- WL, 32, data/address word length in bits (WL/8 byte lanes, WL/8 = 4).
- RAM_DEPTH, 8192, RAM depth in words.
- RAM_ADDR_WL, $clog2(RAM_DEPTH-1), word address width (13 at default).
- ERR_CNT_WL, 8, width of saturating error counter.

Ports:
- clk  in  1  system clock.
- resetn  in  1  asynchronous active-low reset.
- mN_cmd_valid  in  1  command valid, N=0,1 (one set of mN_* ports per requester).
- mN_cmd_ready  out  1  command accepted this cycle.
- mN_cmd_wr  in  1  1=write, 0=read.
- mN_cmd_addr  in  WL  byte address.
- mN_cmd_data  in  WL  write data, already lane-aligned by requester.
- mN_cmd_size  in  2  0=byte, 1=half, 2/3=word.
- mN_rsp_valid  out  1  read response valid.
- mN_rsp_error  out  1  read response error (out of range).
- mN_rsp_data  out  WL  read data.
- ram_we  out  WL/8  byte write enables to RAM data port.
- ram_addr  out  RAM_ADDR_WL  word address to RAM data port.
- ram_din  out  WL  write data to RAM.
- ram_dout  in  WL  RAM read data, valid 1 cycle after address.
- err_count  out  ERR_CNT_WL  saturating count of out-of-range accesses.

Behaviour:

Reset:
- Asynchronous, active-low.
- While resetn=0: mN_cmd_ready=0, mN_rsp_valid=0, mN_rsp_error=0, mN_rsp_data=0, ram_we=0, err_count=0.
- Internal state on reset: last_grant=1 (m0 wins the first tie), rsp_pend=0.

Arbitration (combinational from registered last_grant):
- Only one valid → that requester is granted.
- Both valid → grant the requester other than last_grant.
- Neither valid → no grant; last_grant is held.
- mN_cmd_ready = grant_N, asserted only in the same cycle as valid; no ready without valid.
- accept = valid & ready. On accept, last_grant <= N at the clock edge.
- Continuous contention alternates m0, m1, m0, ...; neither requester waits more than 1 cycle.

Address/enables:
- ram_addr = addr[RAM_ADDR_WL+1:2] of the granted command.
- ram_din = granted cmd_data.
- Out-of-range: addr[WL-1:RAM_ADDR_WL+2] != 0.
- Byte enables for a write that is in range:
  - size 0: 4'b0001 << addr[1:0].
  - size 1: 4'b0011 << {addr[1],1'b0}.
  - size 2/3: 4'b1111.
- In all other cases ram_we=0: write out of range, read, or no grant.
- Misaligned low address bits for half/word accesses are ignored, not flagged.

Response pipeline (registered, 1 cycle latency):
- An accepted read at cycle T produces mN_rsp_valid=1 for exactly one cycle at T+1, on the issuing requester only.
- rsp_data = ram_dout; rsp_error = out-of-range flag captured at T.
- On error, rsp_data = 0.
- Writes produce no response.
- Back-to-back reads (including alternating owners) give one response per cycle with no bubbles.
- The non-owner's rsp_valid stays 0, and its rsp_data holds its previous value.

Error counter:
- Increments by 1 on every accepted out-of-range access, read or write.
- Saturates at all-ones.

Simultaneous events / reset mid-operation:
- Reset asserted with a read in flight: the response is discarded and rsp_valid stays 0 after reset release.
- The first cycle after release behaves as post-reset, with m0 favoured.

Test Plan:
- Single write then read: m0 writes 0xDEADBEEF to addr 0x10 (size 2) → ram_we=4'b1111, ram_addr=4. Next m0 read of 0x10 → m0_rsp_valid at T+1 with data 0xDEADBEEF; m1_rsp_valid=0.
- Byte/half enables: m1 size 0 at addr 0x23 → ram_we=4'b1000, ram_addr=8. m1 size 1 at 0x22 → ram_we=4'b1100.
- Contention: m0 and m1 both hold reads valid for 4 cycles after reset → grants m0, m1, m0, m1. Responses arrive at T+1 on the matching owner with no gaps.
- Out of range: m0 reads 0x0001_0000 → m0_rsp_error=1, rsp_data=0, err_count=1. m1 write to the same address → ram_we=0, err_count=2. 300 such accesses → err_count saturates at 255.
- Reset mid-read: m1 read accepted, resetn low before T+1 → m1_rsp_valid stays 0. After release, a simultaneous m0/m1 request grants m0 first.
